// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: the broadcast packet seen by RS/ROB and the per-FU completion entry.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE  = 32;
    localparam int XLEN      = 32;
    localparam int CDB_TAG_W = $clog2(ROB_SIZE);

    // RS/ROB consumers predate target_pc and ignore it.
    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] Tag;
        logic [XLEN-1:0]      Value;
        logic                 take_branch;
        logic [XLEN-1:0]      target_pc;
    } CDB_PACKET;

    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
        logic [XLEN-1:0]      target_pc;
    } FU_CDB_PACKET;

    function automatic CDB_PACKET to_cdb(input FU_CDB_PACKET e);
        CDB_PACKET p;
        p.valid       = 1'b1;
        p.Tag         = e.tag;
        p.Value       = e.value;
        p.take_branch = e.take_branch;
        p.target_pc   = e.target_pc;
        return p;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU completion buffer: BUF_DEPTH-entry FIFO of FU_CDB_PACKET with synchronous flush.
module cdb_fifo import cdb_arbiter_pkg::*; #(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  FU_CDB_PACKET push_data_i,
    input  logic         pop_i,
    output FU_CDB_PACKET head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    FU_CDB_PACKET     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Power-of-two depth lets pointers wrap naturally; a single entry never moves.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (BUF_DEPTH == 1) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_o    = (count_q == CNT_W'(BUF_DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[head_q];
    assign do_push_s = push_i && !full_o && !flush_i;
    assign do_pop_s  = pop_i && !empty_o && !flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = do_pop_s  ? ptr_inc(head_q) : head_q;
            tail_d = do_push_s ? ptr_inc(tail_q) : tail_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-FU completion buffers with a registered broadcast.
// Optional CDB_BYPASS_EN: a lone completion into idle buffers is broadcast one cycle earlier.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int N_FU      = 3,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = $clog2(ROB_SIZE),
    parameter int XLEN      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_FU-1:0]        fu_valid_i,
    input  logic [N_FU*TAG_W-1:0]  fu_tag_i,
    input  logic [N_FU*XLEN-1:0]   fu_value_i,
    input  logic [N_FU-1:0]        fu_take_branch_i,
    input  logic [N_FU*XLEN-1:0]   fu_target_pc_i,
    output logic [N_FU-1:0]        fu_ready_o,
    output CDB_PACKET              cdb_packet_o
);

    localparam int RR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] idx);
        if (idx == RR_W'(N_FU - 1)) begin
            return '0;
        end else begin
            return idx + RR_W'(1);
        end
    endfunction

    CDB_PACKET        cdb_q, cdb_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    FU_CDB_PACKET     fu_entry_s [N_FU];
    FU_CDB_PACKET     head_s     [N_FU];
    logic [N_FU-1:0]  full_s, empty_s, accept_s, push_s, pop_s;
    logic             flush_s, grant_vld_s, grant_hit_s, bypass_s;
    logic [RR_W-1:0]  grant_idx_s, scan_s, bypass_idx_s;

    // A registered taken-branch broadcast squashes everything in flight this cycle.
    assign flush_s      = cdb_q.valid && cdb_q.take_branch;
    assign fu_ready_o   = ~full_s & {N_FU{~reset}};
    assign accept_s     = fu_valid_i & fu_ready_o & {N_FU{~flush_s}};
    assign push_s       = bypass_s ? '0 : accept_s;
    assign pop_s        = (grant_vld_s && !flush_s) ? (N_FU'(1'b1) << grant_idx_s) : '0;
    assign cdb_packet_o = cdb_q;

    for (genvar i = 0; i < N_FU; i++) begin : g_fu
        assign fu_entry_s[i] = '{tag:         fu_tag_i[i*TAG_W +: TAG_W],
                                 value:       fu_value_i[i*XLEN +: XLEN],
                                 take_branch: fu_take_branch_i[i],
                                 target_pc:   fu_target_pc_i[i*XLEN +: XLEN]};

        cdb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .flush_i     (flush_s),
            .push_i      (push_s[i]),
            .push_data_i (fu_entry_s[i]),
            .pop_i       (pop_s[i]),
            .head_o      (head_s[i]),
            .full_o      (full_s[i]),
            .empty_o     (empty_s[i])
        );
    end

    // First non-empty buffer at or after rr_q, wrapping mod N_FU.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_hit_s = 1'b0;
        grant_idx_s = rr_q;
        scan_s      = rr_q;
        for (int k = 0; k < N_FU; k++) begin
            grant_hit_s = !grant_vld_s && !empty_s[scan_s];
            grant_idx_s = grant_hit_s ? scan_s : grant_idx_s;
            grant_vld_s = grant_vld_s | grant_hit_s;
            scan_s      = rr_next(scan_s);
        end
    end

`ifdef CDB_BYPASS_EN
    always_comb begin
        bypass_idx_s = '0;
        for (int k = 0; k < N_FU; k++) begin
            bypass_idx_s = accept_s[k] ? RR_W'(k) : bypass_idx_s;
        end
        bypass_s = (&empty_s) && !flush_s && ($countones(accept_s) == 32'd1);
    end
`else
    assign bypass_s     = 1'b0;
    assign bypass_idx_s = '0;
`endif

    always_comb begin
        cdb_d = '0;
        rr_d  = rr_q;
        if (flush_s) begin
            cdb_d = '0;
            rr_d  = rr_q;
        end else if (grant_vld_s) begin
            cdb_d = to_cdb(head_s[grant_idx_s]);
            rr_d  = rr_next(grant_idx_s);
        end else if (bypass_s) begin
            cdb_d = to_cdb(fu_entry_s[bypass_idx_s]);
            rr_d  = rr_next(bypass_idx_s);
        end else begin
            cdb_d = '0;
            rr_d  = rr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_q <= '0;
            rr_q  <= '0;
        end else begin
            cdb_q <= cdb_d;
            rr_q  <= rr_d;
        end
    end

endmodule
